// File: rtl/pc_resp_tx.sv
// PC return-path transmitter: frames a snapshotted test report as 11 checksummed bytes.
// Latency: SOF is valid the cycle after rpt_req; back-to-back frames have no idle cycle.
// Backpressure: each byte is held until valid&&ready; a stall of TIMEOUT_CYCLES aborts the frame.
module pc_resp_tx #(
  parameter logic [7:0] SOF_BYTE       = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rpt_req,
  input  logic [7:0]  rpt_type,
  input  logic [31:0] rpt_err_count,
  input  logic [15:0] rpt_adc_data,
  input  logic [7:0]  rpt_status,
  input  logic        err_clr,
  output logic        pc_rsp_valid,
  output logic [7:0]  pc_rsp_data,
  input  logic        pc_rsp_ready,
  output logic        rpt_busy,
  output logic        frame_done,
  output logic        timeout_err,
  output logic        overrun
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [3:0] LAST_IDX = 4'd10;

  typedef enum logic {IDLE, SEND} state_t;

  typedef struct packed {
    logic [7:0]  typ;
    logic [31:0] err;
    logic [15:0] adc;
    logic [7:0]  status;
  } rpt_t;

  state_t          state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  rpt_t            cur_q, cur_d;
  rpt_t            pend_q, pend_d;
  logic            pend_full_q, pend_full_d;
  logic [CW-1:0]   stall_q, stall_d;
  logic            frame_done_q, frame_done_d;
  logic            timeout_err_q, timeout_err_d;
  logic            overrun_q, overrun_d;

  rpt_t            req_rpt;
  logic            xfer;
  logic            stall;
  logic            tmo_hit;
  logic            tmo_set;
  logic            ovr_set;
  logic            last_xfer;
  logic [7:0]      sum;
  logic [7:0]      chk;
  logic [7:0]      byte_mux;

  assign req_rpt   = {rpt_type, rpt_err_count, rpt_adc_data, rpt_status};
  assign xfer      = (state_q == SEND) & pc_rsp_ready;
  assign stall     = (state_q == SEND) & ~pc_rsp_ready;
  assign last_xfer = xfer & (idx_q == LAST_IDX);
  // The stall that would be the TIMEOUT_CYCLES-th in a row is the one that aborts.
  assign tmo_hit   = (TIMEOUT_CYCLES != 0) && stall &&
                     ({{(32-CW){1'b0}}, stall_q} == 32'(TIMEOUT_CYCLES - 1));

  // Frame sequencing, pending slot and sticky error flags.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cur_d         = cur_q;
    pend_d        = pend_q;
    pend_full_d   = pend_full_q;
    stall_d       = stall_q;
    frame_done_d  = 1'b0;
    tmo_set       = 1'b0;
    ovr_set       = 1'b0;
    case (state_q)
      IDLE: begin
        stall_d = '0;
        idx_d   = '0;
        if (pend_full_q) begin
          // Only reachable right after an abort: the queued report goes out now.
          cur_d       = pend_q;
          state_d     = SEND;
          pend_full_d = rpt_req;
          if (rpt_req) pend_d = req_rpt;
        end else if (rpt_req) begin
          cur_d   = req_rpt;
          state_d = SEND;
        end
      end
      SEND: begin
        if (xfer) begin
          stall_d = '0;
          if (last_xfer) begin
            frame_done_d = 1'b1;
            idx_d        = '0;
            if (pend_full_q) begin
              cur_d       = pend_q;
              pend_full_d = rpt_req;
              if (rpt_req) pend_d = req_rpt;
            end else if (rpt_req) begin
              cur_d = req_rpt;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else if (tmo_hit) begin
          state_d = IDLE;
          stall_d = '0;
          idx_d   = '0;
          tmo_set = 1'b1;
        end else begin
          stall_d = stall_q + CW'(1);
        end
        // Requests during a frame (other than at the final CHK) go to the pending slot.
        if (rpt_req && !last_xfer) begin
          pend_d      = req_rpt;
          pend_full_d = 1'b1;
          ovr_set     = pend_full_q;
        end
      end
      default: state_d = IDLE;
    endcase
    // A set event in the same cycle as err_clr wins.
    timeout_err_d = tmo_set | (timeout_err_q & ~err_clr);
    overrun_d     = ovr_set | (overrun_q & ~err_clr);
  end

  // Byte selection for the current index; CHK makes bytes 1..10 sum to zero.
  always_comb begin
    sum = cur_q.typ + 8'h07 + cur_q.err[31:24] + cur_q.err[23:16] + cur_q.err[15:8] +
          cur_q.err[7:0] + cur_q.adc[15:8] + cur_q.adc[7:0] + cur_q.status;
    chk = 8'h00 - sum;
    case (idx_q)
      4'd0:    byte_mux = SOF_BYTE;
      4'd1:    byte_mux = cur_q.typ;
      4'd2:    byte_mux = 8'h07;
      4'd3:    byte_mux = cur_q.err[31:24];
      4'd4:    byte_mux = cur_q.err[23:16];
      4'd5:    byte_mux = cur_q.err[15:8];
      4'd6:    byte_mux = cur_q.err[7:0];
      4'd7:    byte_mux = cur_q.adc[15:8];
      4'd8:    byte_mux = cur_q.adc[7:0];
      4'd9:    byte_mux = cur_q.status;
      default: byte_mux = chk;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      cur_q         <= '0;
      pend_q        <= '0;
      pend_full_q   <= 1'b0;
      stall_q       <= '0;
      frame_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cur_q         <= cur_d;
      pend_q        <= pend_d;
      pend_full_q   <= pend_full_d;
      stall_q       <= stall_d;
      frame_done_q  <= frame_done_d;
      timeout_err_q <= timeout_err_d;
      overrun_q     <= overrun_d;
    end
  end

  assign pc_rsp_valid = (state_q == SEND);
  assign pc_rsp_data  = (state_q == SEND) ? byte_mux : 8'h00;
  assign rpt_busy     = (state_q != IDLE) | pend_full_q;
  assign frame_done   = frame_done_q;
  assign timeout_err  = timeout_err_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_pc_resp_tx.sv
// Bench for pc_resp_tx: directed scenarios then random traffic against a frame-level model.
// Inputs are driven and outputs sampled on the falling edge.
// The model tracks frames as byte queues plus one pending report.
module tb_pc_resp_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rpt_req;
  logic [7:0]  rpt_type;
  logic [31:0] rpt_err_count;
  logic [15:0] rpt_adc_data;
  logic [7:0]  rpt_status;
  logic        err_clr;
  logic        pc_rsp_valid;
  logic [7:0]  pc_rsp_data;
  logic        pc_rsp_ready;
  logic        rpt_busy;
  logic        frame_done;
  logic        timeout_err;
  logic        overrun;

  always #5 clk = ~clk;

  pc_resp_tx #(.SOF_BYTE(8'hA5), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .rpt_req(rpt_req), .rpt_type(rpt_type),
    .rpt_err_count(rpt_err_count), .rpt_adc_data(rpt_adc_data), .rpt_status(rpt_status),
    .err_clr(err_clr), .pc_rsp_valid(pc_rsp_valid), .pc_rsp_data(pc_rsp_data),
    .pc_rsp_ready(pc_rsp_ready), .rpt_busy(rpt_busy), .frame_done(frame_done),
    .timeout_err(timeout_err), .overrun(overrun)
  );

  int nchk = 0;
  int nerr = 0;

  // Reference model: bytes still to send for the frame on the wire, plus one pending report.
  logic [7:0]  exp_q[$];
  bit          m_act, m_pend_v, m_fd, m_tmo, m_ovr;
  int          m_stall;
  logic [63:0] m_pend;

  logic [7:0]  rx_q[$];
  int          stall_obs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void start_frame(input logic [63:0] r);
    logic [7:0] b[11];
    int sum;
    b[0] = 8'hA5;      b[1] = r[63:56];  b[2] = 8'h07;
    b[3] = r[55:48];   b[4] = r[47:40];  b[5] = r[39:32];  b[6] = r[31:24];
    b[7] = r[23:16];   b[8] = r[15:8];   b[9] = r[7:0];
    sum = 0;
    for (int i = 1; i < 10; i++) sum += int'(b[i]);
    b[10] = 8'((256 - (sum % 256)) % 256);
    for (int i = 0; i < 11; i++) exp_q.push_back(b[i]);
    m_act   = 1'b1;
    m_stall = 0;
  endfunction

  // One clock: check outputs against the model, drive inputs, advance the model.
  task automatic cyc(input bit req, input bit rdy, input bit clr, input bit rst,
                     input logic [63:0] r);
    bit abort_now;
    bit ovr_set;
    chk("valid", {31'd0, pc_rsp_valid}, {31'd0, m_act});
    chk("busy", {31'd0, rpt_busy}, {31'd0, m_act | m_pend_v});
    chk("frame_done", {31'd0, frame_done}, {31'd0, m_fd});
    chk("timeout_err", {31'd0, timeout_err}, {31'd0, m_tmo});
    chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
    if (m_act && exp_q.size() > 0) chk("data", {24'd0, pc_rsp_data}, {24'd0, exp_q[0]});

    rpt_req = req; pc_rsp_ready = rdy; err_clr = clr; rst_n = !rst;
    {rpt_type, rpt_err_count, rpt_adc_data, rpt_status} = r;
    if (!rst && pc_rsp_valid && rdy) rx_q.push_back(pc_rsp_data);
    if (!rst && pc_rsp_valid && !rdy) stall_obs++;

    abort_now = 1'b0;
    ovr_set   = 1'b0;
    if (rst) begin
      exp_q.delete();
      m_act = 0; m_pend_v = 0; m_fd = 0; m_tmo = 0; m_ovr = 0; m_stall = 0;
    end else begin
      m_fd = 1'b0;
      if (m_act) begin
        if (rdy) begin
          void'(exp_q.pop_front());
          m_stall = 0;
          if (exp_q.size() == 0) begin
            m_act = 1'b0;
            m_fd  = 1'b1;
            if (m_pend_v) begin start_frame(m_pend); m_pend_v = 1'b0; end
          end
        end else begin
          m_stall++;
          if (m_stall == 16) begin
            exp_q.delete();
            m_act     = 1'b0;
            abort_now = 1'b1;
          end
        end
      end else if (m_pend_v) begin
        start_frame(m_pend);
        m_pend_v = 1'b0;
      end
      if (req) begin
        if (m_act || abort_now) begin
          ovr_set  = m_pend_v;
          m_pend   = r;
          m_pend_v = 1'b1;
        end else begin
          start_frame(r);
        end
      end
      m_tmo = abort_now | (m_tmo & !clr);
      m_ovr = ovr_set | (m_ovr & !clr);
    end
    @(negedge clk);
  endtask

  logic [63:0] r1, r3b, r3c, rr;
  logic [7:0]  gold[11];
  int          cnt;

  initial begin
    rst_n = 1'b0; rpt_req = 1'b0; pc_rsp_ready = 1'b0; err_clr = 1'b0;
    rpt_type = '0; rpt_err_count = '0; rpt_adc_data = '0; rpt_status = '0;
    exp_q.delete(); rx_q.delete();
    m_act = 0; m_pend_v = 0; m_fd = 0; m_tmo = 0; m_ovr = 0; m_stall = 0; m_pend = '0;
    stall_obs = 0;
    r1   = {8'h01, 32'h0000_0003, 16'h1234, 8'h81};
    r3b  = {8'h01, 32'hFFFF_FFFF, 16'h1234, 8'h81};
    r3c  = {8'h01, 32'h0000_0005, 16'h1234, 8'h81};
    gold = '{8'hA5, 8'h01, 8'h07, 8'h00, 8'h00, 8'h00, 8'h03, 8'h12, 8'h34, 8'h81, 8'h2E};
    @(negedge clk);

    // Reset state.
    cyc(0, 0, 0, 1, '0);
    cyc(0, 0, 0, 1, '0);
    chk("rst_data", {24'd0, pc_rsp_data}, 32'd0);
    cyc(0, 1, 0, 0, '0);

    // 1: full-rate frame; inputs scrambled after the snapshot.
    rx_q.delete();
    cyc(1, 1, 0, 0, r1);
    repeat (13) cyc(0, 1, 0, 0, {$urandom, $urandom});
    chk("t1_len", rx_q.size(), 32'd11);
    for (int i = 0; i < 11; i++) chk("t1_byte", {24'd0, rx_q[i]}, {24'd0, gold[i]});

    // 2: ready toggling every cycle.
    rx_q.delete();
    cyc(1, 1, 0, 0, r1);
    for (int i = 0; i < 26; i++) cyc(0, (i % 2) == 1, 0, 0, {$urandom, $urandom});
    chk("t2_len", rx_q.size(), 32'd11);
    for (int i = 0; i < 11; i++) chk("t2_byte", {24'd0, rx_q[i]}, {24'd0, gold[i]});

    // 3: two requests during a frame overwrite the pending slot.
    rx_q.delete();
    cyc(1, 1, 0, 0, r1);
    for (int i = 1; i <= 30; i++)
      cyc(i == 5 || i == 8, 1, 0, 0, (i == 5) ? r3b : (i == 8) ? r3c : {$urandom, $urandom});
    chk("t3_overrun", {31'd0, overrun}, 32'd1);
    chk("t3_len", rx_q.size(), 32'd22);
    chk("t3_sof2", {24'd0, rx_q[11]}, 32'hA5);
    chk("t3_err3", {24'd0, rx_q[14]}, 32'h00);
    chk("t3_err2", {24'd0, rx_q[15]}, 32'h00);
    chk("t3_err1", {24'd0, rx_q[16]}, 32'h00);
    chk("t3_err0", {24'd0, rx_q[17]}, 32'h05);
    cyc(0, 1, 1, 0, '0);

    // 4: stall at byte 4 until abort, then a fresh frame.
    rx_q.delete();
    stall_obs = 0;
    cyc(1, 1, 0, 0, r1);
    for (int i = 1; i <= 4; i++) cyc(0, 1, 0, 0, '0);
    repeat (20) cyc(0, 0, 0, 0, '0);
    chk("t4_stalls", stall_obs, 32'd16);
    chk("t4_timeout_err", {31'd0, timeout_err}, 32'd1);
    chk("t4_bytes", rx_q.size(), 32'd4);
    rx_q.delete();
    rr = {$urandom, $urandom};
    cyc(1, 1, 0, 0, rr);
    repeat (13) cyc(0, 1, 0, 0, '0);
    chk("t4_len2", rx_q.size(), 32'd11);
    chk("t4_sof2", {24'd0, rx_q[0]}, 32'hA5);
    cyc(0, 1, 1, 0, '0);

    // 5: reset mid-frame with a pending request.
    rx_q.delete();
    cyc(1, 1, 0, 0, r1);
    for (int i = 1; i <= 6; i++) cyc(i == 2, 1, 0, i == 6, {$urandom, $urandom});
    chk("t5_valid", {31'd0, pc_rsp_valid}, 32'd0);
    chk("t5_busy", {31'd0, rpt_busy}, 32'd0);
    chk("t5_data", {24'd0, pc_rsp_data}, 32'd0);
    cnt = rx_q.size();
    repeat (15) cyc(0, 1, 0, 0, '0);
    chk("t5_no_bytes", rx_q.size(), cnt);

    // 6: err_clr coinciding with a new overrun.
    cyc(1, 1, 0, 0, r1);
    cyc(1, 1, 0, 0, r3b);
    cyc(1, 1, 0, 0, r3c);
    cyc(1, 1, 1, 0, r1);
    chk("t6_overrun_held", {31'd0, overrun}, 32'd1);
    cyc(0, 1, 1, 0, '0);
    chk("t6_overrun_clr", {31'd0, overrun}, 32'd0);
    repeat (30) cyc(0, 1, 0, 0, '0);

    // Random traffic.
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(7) == 0, $urandom_range(3) != 0, $urandom_range(31) == 0, 0,
          {$urandom, $urandom});
    repeat (40) cyc(0, 1, 0, 0, '0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
